// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with a one-word holding register,
// valid/ready output handshake and a sticky overrun flag.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift_en,
  input  logic                     serial_in,
  input  logic                     clear,
  input  logic                     data_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     busy,
  output logic                     overrun
);

  // state | meaning
  // EMPTY | holding register has no unaccepted word (data_valid=0)
  // FULL  | holding register presents a word awaiting data_ready (data_valid=1)

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  always_comb begin
    shifted = LSB_FIRST ? {serial_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], serial_in};
    // the completing edge hands over the word including the bit sampled now
    complete = shift_en && !clear && (bit_count == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      sr         <= '0;
      hold       <= '0;
      bit_count  <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clear) begin
        sr        <= '0;
        bit_count <= '0;
        overrun   <= 1'b0;
      end else if (shift_en) begin
        sr        <= shifted;
        bit_count <= (bit_count == LAST) ? '0 : bit_count + CW'(1);
      end

      case (state)
        EMPTY: begin
          if (complete) begin
            hold       <= shifted;
            state      <= FULL;
            data_valid <= 1'b1;
          end
        end
        FULL: begin
          if (complete && data_ready) begin
            hold <= shifted;
          end else if (complete) begin
            overrun <= 1'b1;
          end else if (data_ready) begin
            state      <= EMPTY;
            data_valid <= 1'b0;
          end
        end
        default: begin
          state      <= EMPTY;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = hold;
  assign busy     = (bit_count != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are
// compared against a bit-queue reference model of the word assembly and handshake.
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         shift_en = 1'b0;
  logic         serial_in = 1'b0;
  logic         clear = 1'b0;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_out, dm_data_out;
  logic         data_valid, dm_data_valid;
  logic [1:0]   bit_count, dm_bit_count;
  logic         busy, dm_busy;
  logic         overrun, dm_overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model
  bit           bits[$];
  logic [W-1:0] m_hold = '0;
  logic [W-1:0] m_hold_msb = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;

  sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .shift_en(shift_en), .serial_in(serial_in),
    .clear(clear), .data_ready(data_ready), .data_out(data_out),
    .data_valid(data_valid), .bit_count(bit_count), .busy(busy), .overrun(overrun)
  );

  sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .shift_en(shift_en), .serial_in(serial_in),
    .clear(clear), .data_ready(data_ready), .data_out(dm_data_out),
    .data_valid(dm_data_valid), .bit_count(dm_bit_count), .busy(dm_busy),
    .overrun(dm_overrun)
  );

  always #5 clk = ~clk;

  // drives one clock of stimulus (called at a falling edge) and advances the model
  task automatic step(input bit se, input bit si, input bit cl, input bit rdy, input bit rst);
    logic [W-1:0] w, wm;
    bit           done;
    reset = rst; shift_en = se; serial_in = si; clear = cl; data_ready = rdy;
    done = 1'b0; w = '0; wm = '0;
    if (rst) begin
      bits.delete();
      m_hold = '0; m_hold_msb = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      if (cl) begin
        bits.delete();
        m_ovr = 1'b0;
      end else if (se) begin
        bits.push_back(si);
        if (bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            w[i] = bits[i];
            wm[W-1-i] = bits[i];
          end
          bits.delete();
          done = 1'b1;
        end
      end
      if (!m_valid) begin
        if (done) begin m_hold = w; m_hold_msb = wm; m_valid = 1'b1; end
      end else if (done && rdy) begin
        m_hold = w; m_hold_msb = wm;
      end else if (done) begin
        m_ovr = 1'b1;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; shift_en = 1'b0; clear = 1'b0; data_ready = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    total_cnt++;
    if (data_out !== 4'h0) $display("FAIL reset_data_out: got %h want 0", data_out);
    else pass_cnt++;
    total_cnt++;
    if (data_valid !== 1'b0 || dm_data_valid !== 1'b0)
      $display("FAIL reset_valid: got %b/%b want 0/0", data_valid, dm_data_valid);
    else pass_cnt++;
    total_cnt++;
    if (bit_count !== 2'd0 || busy !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_status: got cnt=%0d busy=%b ovr=%b want 0/0/0", bit_count, busy, overrun);
    else pass_cnt++;
  endtask

  task automatic test_lsb_receive();
    bit       seq[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit [1:0] cnt_exp[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (bit_count !== cnt_exp[i])
        $display("FAIL lsb_bit_count[%0d]: got %0d want %0d", i, bit_count, cnt_exp[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (data_out !== 4'hD || data_valid !== 1'b1)
      $display("FAIL lsb_word: got %h valid=%b want d valid=1", data_out, data_valid);
    else pass_cnt++;
    total_cnt++;
    if (dm_data_out !== 4'hB)
      $display("FAIL msb_of_1011: got %h want b", dm_data_out);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (data_valid !== 1'b0 || data_out !== 4'hD)
      $display("FAIL accept: got valid=%b out=%h want 0/d", data_valid, data_out);
    else pass_cnt++;
  endtask

  task automatic test_loopback();
    logic [W-1:0] piso = 4'hA;
    for (int i = 0; i < W; i++) begin
      step(1'b1, piso[0], 1'b0, 1'b0, 1'b0);
      piso = piso >> 1;
    end
    total_cnt++;
    if (data_out !== 4'hA || data_valid !== 1'b1)
      $display("FAIL loopback: got %h valid=%b want a valid=1", data_out, data_valid);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    logic [W-1:0] a = 4'h3, b = 4'h5;
    for (int i = 0; i < W; i++) step(1'b1, a[i], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) step(1'b1, b[i], 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (data_out !== 4'h3 || overrun !== 1'b1 || data_valid !== 1'b1)
      $display("FAIL overrun_set: got out=%h ovr=%b valid=%b want 3/1/1", data_out, overrun, data_valid);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (overrun !== 1'b0 || data_valid !== 1'b1 || data_out !== 4'h3)
      $display("FAIL overrun_clear: got ovr=%b valid=%b out=%h want 0/1/3", overrun, data_valid, data_out);
    else pass_cnt++;
  endtask

  task automatic test_accept_complete();
    logic [W-1:0] c = 4'hC;
    for (int i = 0; i < W; i++) step(1'b1, c[i], 1'b0, (i == W-1), 1'b0);
    total_cnt++;
    if (data_out !== 4'hC || data_valid !== 1'b1 || overrun !== 1'b0)
      $display("FAIL accept_complete: got out=%h valid=%b ovr=%b want c/1/0", data_out, data_valid, overrun);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_clear_mid();
    bit seq[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (bit_count !== 2'd0 || busy !== 1'b0)
      $display("FAIL clear_mid_count: got cnt=%0d busy=%b want 0/0", bit_count, busy);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (data_out !== 4'h6 || data_valid !== 1'b1)
      $display("FAIL clear_mid_word: got %h valid=%b want 6 valid=1", data_out, data_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    // still FULL with 4'h6 from the previous scenario
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (data_out !== 4'h0 || data_valid !== 1'b0 || bit_count !== 2'd0 || busy !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_mid: got out=%h valid=%b cnt=%0d busy=%b ovr=%b want all 0",
               data_out, data_valid, bit_count, busy, overrun);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (data_out !== 4'hF || data_valid !== 1'b1)
      $display("FAIL reset_mid_word: got %h valid=%b want f valid=1", data_out, data_valid);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_msb_receive();
    bit seq[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (dm_data_out !== 4'h8 || dm_data_valid !== 1'b1)
      $display("FAIL msb_word: got %h valid=%b want 8 valid=1", dm_data_out, dm_data_valid);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 4'h1)
      $display("FAIL lsb_of_1000: got %h want 1", data_out);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit se, si, cl, rdy, rst;
    for (int n = 0; n < 400; n++) begin
      se  = ($urandom_range(0, 3) != 0);
      si  = 1'($urandom_range(0, 1));
      cl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(se, si, cl, rdy, rst);
      total_cnt++;
      if (data_out !== m_hold || dm_data_out !== m_hold_msb)
        $display("FAIL rand_data[%0d]: got %h/%h want %h/%h", n, data_out, dm_data_out, m_hold, m_hold_msb);
      else pass_cnt++;
      total_cnt++;
      if (data_valid !== m_valid || dm_data_valid !== m_valid || overrun !== m_ovr || dm_overrun !== m_ovr)
        $display("FAIL rand_flags[%0d]: got valid=%b/%b ovr=%b/%b want %b/%b",
                 n, data_valid, dm_data_valid, overrun, dm_overrun, m_valid, m_ovr);
      else pass_cnt++;
      total_cnt++;
      if (int'(bit_count) !== bits.size() || int'(dm_bit_count) !== bits.size() ||
          busy !== (bits.size() != 0) || dm_busy !== (bits.size() != 0))
        $display("FAIL rand_count[%0d]: got %0d/%0d busy=%b/%b want %0d", n,
                 bit_count, dm_bit_count, busy, dm_busy, bits.size());
      else pass_cnt++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lsb_receive();
    test_loopback();
    test_overrun();
    test_accept_complete();
    test_clear_mid();
    test_reset_mid();
    test_msb_receive();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
